// File: rtl/mesh_pkg.sv
// Shared mesh constants (PE count, index and word widths) and the readout FSM
// state encoding used by the mesh, its readout stage and their benches.
package mesh_pkg;

   localparam int MESH_WIDTH      = 256;
   localparam int MESH_ADDR_WIDTH = 8;
   localparam int MESH_DATA_WIDTH = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_SCAN = 2'd2,
      ST_DONE = 2'd3
   } readout_state_e;

endpackage

// File: rtl/mesh_readout_mux.sv
// Combinational N:1 word select of the readout snapshot register by PE index.
module mesh_readout_mux
   import mesh_pkg::*;
#(
   parameter int N          = MESH_WIDTH,
   parameter int ADDR_WIDTH = MESH_ADDR_WIDTH,
   parameter int DATA_WIDTH = MESH_DATA_WIDTH
) (
   input  logic [N*DATA_WIDTH-1:0] snap_i,
   input  logic [ADDR_WIDTH-1:0]   sel_i,
   output logic [DATA_WIDTH-1:0]   data_o
);

   logic [DATA_WIDTH-1:0] words_s [N];

   for (genvar k = 0; k < N; k++) begin : g_word
      assign words_s[k] = snap_i[k*DATA_WIDTH +: DATA_WIDTH];
   end

   // N is a power of two, so every sel_i value addresses a real word.
   assign data_o = words_s[sel_i];

endmodule

// File: rtl/mesh_readout.sv
// Mesh drain stage: settle wait, snapshot of all PE words, ordered (addr, data)
// valid/ready stream. Optional running checksum port under MESH_READOUT_CHECKSUM_EN.
module mesh_readout
   import mesh_pkg::*;
#(
   parameter int N           = MESH_WIDTH,
   parameter int ADDR_WIDTH  = MESH_ADDR_WIDTH,
   parameter int DATA_WIDTH  = MESH_DATA_WIDTH,
   parameter int SORT_CYCLES = 112
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [N*DATA_WIDTH-1:0] pe_mem,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [ADDR_WIDTH-1:0]   out_addr,
   output logic [DATA_WIDTH-1:0]   out_data,
   output logic                    busy,
   output logic                    done
`ifdef MESH_READOUT_CHECKSUM_EN
   ,
   output logic [DATA_WIDTH-1:0]   checksum
`endif
);

   localparam int                    CNT_W    = (SORT_CYCLES > 1) ? $clog2(SORT_CYCLES) : 1;
   localparam logic [CNT_W-1:0]      CNT_LOAD = CNT_W'(SORT_CYCLES - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(N - 1);

   readout_state_e          state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
   logic [N*DATA_WIDTH-1:0] snap_q, snap_d;
   logic                    valid_q, valid_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic [ADDR_WIDTH-1:0]   next_idx_s;
   logic [DATA_WIDTH-1:0]   mux_data_s;
   logic                    xfer_s;

   assign xfer_s     = valid_q & out_ready;
   assign next_idx_s = idx_q + ADDR_WIDTH'(1);

   mesh_readout_mux #(
      .N          (N),
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_mux (
      .snap_i (snap_q),
      .sel_i  (next_idx_s),
      .data_o (mux_data_s)
   );

   // Next-state and output decode; the following beat is pre-selected so a
   // transfer can be followed by a new beat without a bubble.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      snap_d  = snap_q;
      valid_d = valid_q;
      data_d  = data_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_WAIT;
               cnt_d   = CNT_LOAD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0) begin
               state_d = ST_SCAN;
               snap_d  = pe_mem;
               idx_d   = '0;
               valid_d = 1'b1;
               data_d  = pe_mem[DATA_WIDTH-1:0];
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_SCAN: begin
            if (xfer_s && (idx_q == LAST_IDX)) begin
               state_d = ST_DONE;
               valid_d = 1'b0;
            end else if (xfer_s) begin
               idx_d  = next_idx_s;
               data_d = mux_data_s;
            end else begin
               valid_d = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
         end
      endcase
      busy_d = (state_d == ST_WAIT) || (state_d == ST_SCAN);
      done_d = (state_d == ST_DONE);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         snap_q  <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         snap_q  <= snap_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign out_valid = valid_q;
   assign out_addr  = idx_q;
   assign out_data  = data_q;
   assign busy      = busy_q;
   assign done      = done_q;

`ifdef MESH_READOUT_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] csum_q, csum_d;

   // Running sum of accepted words, restarted when a drain is launched.
   always_comb begin
      if ((state_q == ST_IDLE) && start) begin
         csum_d = '0;
      end else if (xfer_s) begin
         csum_d = csum_q + data_q;
      end else begin
         csum_d = csum_q;
      end
   end

   // Checksum register.
   always_ff @(posedge clk) begin
      if (rst) begin
         csum_q <= '0;
      end else begin
         csum_q <= csum_d;
      end
   end

   assign checksum = csum_q;
`endif

endmodule

// File: tb/tb_mesh_readout.sv
// Randomized self-checking bench for mesh_readout against a beat-count scoreboard.
// Define MESH_READOUT_CHECKSUM_EN to also check the checksum port.
module tb_mesh_readout;

   localparam int N  = 256;
   localparam int AW = 8;
   localparam int DW = 8;
   localparam int SC = 112;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic            out_ready;
   logic [N*DW-1:0] pe_mem;
   logic            out_valid;
   logic [AW-1:0]   out_addr;
   logic [DW-1:0]   out_data;
   logic            busy;
   logic            done;
`ifdef MESH_READOUT_CHECKSUM_EN
   logic [DW-1:0]   checksum;
`endif

   logic [DW-1:0]   pe_arr [N];
   int              n_checks = 0;
   int              n_pass   = 0;

   always #5 clk = ~clk;

   always_comb begin
      pe_mem = '0;
      for (int k = 0; k < N; k++) pe_mem[k*DW +: DW] = pe_arr[k];
   end

   mesh_readout #(
      .N(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SORT_CYCLES(SC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .pe_mem    (pe_mem),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_addr  (out_addr),
      .out_data  (out_data),
      .busy      (busy),
      .done      (done)
`ifdef MESH_READOUT_CHECKSUM_EN
      , .checksum (checksum)
`endif
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One drain. mode: 0 ready high, 1 ready alternating, 2 ready random.
   // Cycle e counts edges after the edge that samples start (e=0).
   task automatic run_drain(input int mode, input bit hold_start, input int change_at,
                            input int rst_beat, input int exp_done);
      logic [DW-1:0] snap [N];
      logic [DW-1:0] sum;
      int            acc;
      int            fin_e;
      int            e;
      bit            ev;
      bit            rdy;
      bit            take;
      snap  = pe_arr;
      sum   = '0;
      for (int k = 0; k < N; k++) sum = sum + snap[k];
      acc   = 0;
      fin_e = -1;
      e     = 0;
      start = 1'b1;
      step();
      while (1) begin
         ev = (e >= SC) && (acc < N);
         check_eq("out_valid", out_valid, ev);
         check_eq("busy", busy, acc < N);
         check_eq("done", done, fin_e == e);
         if (ev) begin
            check_eq($sformatf("addr_beat%0d", acc), out_addr, acc);
            check_eq($sformatf("data_beat%0d", acc), out_data, snap[acc]);
         end
`ifdef MESH_READOUT_CHECKSUM_EN
         if (e == 0) check_eq("checksum_clear", checksum, 0);
         if (fin_e >= 0) check_eq("checksum", checksum, sum);
`endif
         if (fin_e >= 0 && e == fin_e + 1) break;
         if (e > SC + 3*N) begin
            check_eq("drain_timeout", e, SC + 3*N);
            break;
         end
         if (rst_beat >= 0 && ev && acc == rst_beat) begin
            rst       = 1'b1;
            start     = 1'b0;
            out_ready = 1'b0;
            step();
            rst = 1'b0;
            check_eq("rst_out_valid", out_valid, 0);
            check_eq("rst_busy", busy, 0);
            check_eq("rst_done", done, 0);
            check_eq("rst_addr", out_addr, 0);
            for (int i = 0; i < 20; i++) begin
               step();
               check_eq("post_rst_valid", out_valid, 0);
               check_eq("post_rst_busy", busy, 0);
            end
            return;
         end
         case (mode)
            0:       rdy = 1'b1;
            1:       rdy = ((e + 1 + SC) % 2) == 1;
            default: rdy = ($urandom_range(0, 3) != 0);
         endcase
         out_ready = rdy;
         start     = hold_start;
         if (e == change_at) begin
            for (int k = 0; k < N; k++) pe_arr[k] = 8'hAA;
         end
         take = ev && rdy;
         step();
         e++;
         if (take) begin
            acc++;
            if (acc == N) fin_e = e;
         end
      end
      start = 1'b0;
      if (exp_done >= 0) check_eq("done_cycle", fin_e, exp_done);
      if (hold_start) begin
         step();
         check_eq("no_restart_busy", busy, 0);
         check_eq("no_restart_valid", out_valid, 0);
      end
   endtask

   task automatic fill_desc();
      for (int k = 0; k < N; k++) pe_arr[k] = 8'(255 - k);
   endtask

   task automatic fill_rand();
      for (int k = 0; k < N; k++) pe_arr[k] = 8'($urandom_range(0, 255));
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      out_ready = 1'b0;
      for (int k = 0; k < N; k++) pe_arr[k] = '0;
      repeat (3) step();
      check_eq("reset_valid", out_valid, 0);
      check_eq("reset_busy", busy, 0);
      check_eq("reset_done", done, 0);
      check_eq("reset_addr", out_addr, 0);
      check_eq("reset_data", out_data, 0);
`ifdef MESH_READOUT_CHECKSUM_EN
      check_eq("reset_checksum", checksum, 0);
`endif
      rst = 1'b0;
      step();

      fill_desc();
      run_drain(0, 1'b0, -1, -1, SC + N);
      fill_desc();
      run_drain(1, 1'b0, -1, -1, SC + 2*N - 1);
      fill_rand();
      run_drain(2, 1'b1, -1, -1, -1);
      fill_desc();
      run_drain(0, 1'b0, 150, -1, SC + N);
      fill_desc();
      run_drain(2, 1'b0, -1, 40, -1);
      fill_desc();
      run_drain(0, 1'b0, -1, -1, SC + N);
      for (int k = 0; k < N; k++) pe_arr[k] = '0;
      run_drain(0, 1'b0, -1, -1, SC + N);
      fill_rand();
      run_drain(2, 1'b0, -1, -1, -1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
